// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared FSM state type and default parameters for the APB arbiter
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting one past the previous winner
module rr_picker
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);

  logic [IW-1:0] cand;
  logic          found;

  // walk the requesters from last_grant+1 around the ring; the first pending one wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin sequencer sharing one APB master port between requesters
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [N_REQ-1:0]  req_write,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]  req_ready,
  output logic [N_REQ-1:0]  rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AW-1:0]     PRWADDR,
  output logic [DW-1:0]     PRWDATA,
  input  logic [DW-1:0]     PRDATA1,
  input  logic              PREADY
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  state_t           state, state_n;
  logic [IW-1:0]    last_grant, last_grant_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic [AW-1:0]    addr_sel, addr_n;
  logic [DW-1:0]    wdata_sel, wdata_n;
  logic             write_sel, pwrite_n;
  logic [N_REQ-1:0] req_ready_n, rsp_valid_n;
  logic [DW-1:0]    rsp_rdata_n;
  logic             rsp_err_n, busy_n, psel_n, penable_n;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_oh),
    .grant_idx  (pick_idx)
  );

  // one-hot select of the winning requester's payload
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    write_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        addr_sel  = req_addr[i*AW +: AW];
        wdata_sel = req_wdata[i*DW +: DW];
        write_sel = req_write[i];
      end
    end
  end

  // next state plus next value of every registered output; holds by default
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    req_ready_n  = '0;
    rsp_valid_n  = '0;
    rsp_rdata_n  = rsp_rdata;
    rsp_err_n    = rsp_err;
    psel_n       = PSEL;
    penable_n    = PENABLE;
    pwrite_n     = PWRITE;
    addr_n       = PRWADDR;
    wdata_n      = PRWDATA;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n      = SETUP;
          last_grant_n = pick_idx;
          req_ready_n  = pick_oh;
          psel_n       = 1'b1;
          penable_n    = 1'b0;
          pwrite_n     = write_sel;
          addr_n       = addr_sel;
          wdata_n      = wdata_sel;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
        cnt_n     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          // ready on the same edge as the limit still completes normally
          state_n                 = IDLE;
          psel_n                  = 1'b0;
          penable_n               = 1'b0;
          rsp_valid_n[last_grant] = 1'b1;
          rsp_err_n               = 1'b0;
          rsp_rdata_n             = PWRITE ? '0 : PRDATA1;
        end else begin
          cnt_n = cnt + CW'(1);
          if ((TIMEOUT != 0) && (cnt_n == TO_LIMIT)) begin
            state_n                 = IDLE;
            psel_n                  = 1'b0;
            penable_n               = 1'b0;
            rsp_valid_n[last_grant] = 1'b1;
            rsp_err_n               = 1'b1;
            rsp_rdata_n             = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // state and output registers; reset drops any in-flight transfer silently
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state      <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      cnt        <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PRWADDR    <= '0;
      PRWDATA    <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      req_ready  <= req_ready_n;
      rsp_valid  <= rsp_valid_n;
      rsp_rdata  <= rsp_rdata_n;
      rsp_err    <= rsp_err_n;
      busy       <= busy_n;
      PSEL       <= psel_n;
      PENABLE    <= penable_n;
      PWRITE     <= pwrite_n;
      PRWADDR    <= addr_n;
      PRWDATA    <= wdata_n;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - self-checking bench for apb_arbiter with queued requesters and a slave model
module tb_apb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, busy, PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PRWADDR;
  logic [DW-1:0]   PRWDATA;
  logic [DW-1:0]   PRDATA1 = '0;
  logic            PREADY = 1'b1;

  apb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRDATA1(PRDATA1), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {logic write; logic [AW-1:0] addr; logic [DW-1:0] wdata;} cmd_t;
  typedef struct {int idx; int cyc; logic write; logic [AW-1:0] addr; logic [DW-1:0] wdata;} grant_t;
  typedef struct {int idx; int cyc; logic [DW-1:0] rdata; logic err;} rsp_t;
  typedef struct {int idx; cmd_t c; int w;} exp_t;

  cmd_t   cmdq[N][$];
  grant_t glog[$];
  rsp_t   rlog[$];
  exp_t   exp_q[$];
  int     wait_plan[$];
  int     slave_wait = 0;
  int     acc_cnt = 0;
  int     cur_wait = 0;
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     model_last = N - 1;
  int     unstable = 0;
  logic [AW+DW:0] held = '0;

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return 32'h4d4f5447 ^ a;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx = -1;
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  always @(posedge PCLK) cyc <= cyc + 1;

  // requesters: present the head of each queue, retire it when req_ready is seen
  always @(negedge PCLK) begin
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && cmdq[i].size() > 0) void'(cmdq[i].pop_front());
      if (cmdq[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_write[i]           = cmdq[i][0].write;
        req_addr[i*AW +: AW]   = cmdq[i][0].addr;
        req_wdata[i*DW +: DW]  = cmdq[i][0].wdata;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // slave: per-transfer wait count taken from wait_plan, junk data while not ready
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (acc_cnt == 0) cur_wait = (wait_plan.size() > 0) ? wait_plan.pop_front() : slave_wait;
      PREADY  = (acc_cnt >= cur_wait);
      PRDATA1 = PREADY ? slave_data(PRWADDR) : $urandom();
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b1;
      PRDATA1 = $urandom();
    end
  end

  // monitor: log grants and completions, count payload changes while selected
  always @(negedge PCLK) begin
    if (|req_ready) begin
      glog.push_back('{onehot_idx(req_ready), cyc, PWRITE, PRWADDR, PRWDATA});
      held = {PWRITE, PRWADDR, PRWDATA};
    end else if (PSEL && ({PWRITE, PRWADDR, PRWDATA} !== held)) begin
      unstable++;
    end
    if (|rsp_valid) rlog.push_back('{onehot_idx(rsp_valid), cyc, rsp_rdata, rsp_err});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic start_batch();
    glog.delete();
    rlog.delete();
    exp_q.delete();
    wait_plan.delete();
    unstable = 0;
  endtask

  // reference: every queued requester stays pending; winner is the next pending one after the last
  task automatic model_build();
    cmd_t pend[N][$];
    int   left = 0;
    int   k = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = cmdq[i];
      left += pend[i].size();
    end
    while (left > 0) begin
      for (int s = 1; s <= N; s++) begin
        int   j;
        cmd_t c;
        int   w;
        j = (model_last + s) % N;
        if (pend[j].size() > 0) begin
          c = pend[j].pop_front();
          w = (k < wait_plan.size()) ? wait_plan[k] : slave_wait;
          exp_q.push_back('{j, c, w});
          model_last = j;
          k++;
          left--;
          break;
        end
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int t = 0;
    while (rlog.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    tick(2);
    ok = (rlog.size() == n) && (glog.size() == n);
  endtask

  task automatic test_reset();
    PRESET = 1'b0;
    tick(3);
    checks++;
    if ({PSEL, PENABLE, PWRITE, busy, rsp_err} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {PSEL, PENABLE, PWRITE, busy, rsp_err}); end
    checks++;
    if ({req_ready, rsp_valid} !== '0)
      begin errors++; $display("FAIL reset_pulses: got %b expected 0", {req_ready, rsp_valid}); end
    checks++;
    if ({PRWADDR, PRWDATA, rsp_rdata} !== '0)
      begin errors++; $display("FAIL reset_data: got %h expected 0", {PRWADDR, PRWDATA, rsp_rdata}); end
    PRESET = 1'b1;
    model_last = N - 1;
    tick(3);
    checks++;
    if ({PSEL, busy, req_ready} !== '0)
      begin errors++; $display("FAIL reset_idle: got %b expected 0", {PSEL, busy, req_ready}); end
  endtask

  task automatic test_all_four();
    bit ok;
    start_batch();
    for (int i = 0; i < N; i++) cmdq[i].push_back('{1'b0, AW'(i * 4), $urandom()});
    model_build();
    wait_done(4, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all4_count: got %0d rsp expected 4", rlog.size()); end
    for (int k = 0; k < 4 && k < rlog.size() && k < glog.size(); k++) begin
      checks++;
      if (glog[k].idx != k || rlog[k].idx != k)
        begin errors++; $display("FAIL all4_order[%0d]: got grant %0d rsp %0d expected %0d", k, glog[k].idx, rlog[k].idx, k); end
      checks++;
      if ({rlog[k].err, rlog[k].rdata} !== {1'b0, slave_data(AW'(k * 4))})
        begin errors++; $display("FAIL all4_rdata[%0d]: got %h expected %h", k, rlog[k].rdata, slave_data(AW'(k * 4))); end
      if (k > 0) begin
        checks++;
        if (rlog[k].cyc - rlog[k-1].cyc != 3)
          begin errors++; $display("FAIL all4_gap[%0d]: got %0d expected 3", k, rlog[k].cyc - rlog[k-1].cyc); end
      end
    end
  endtask

  task automatic test_alternating();
    bit ok;
    start_batch();
    for (int n = 0; n < 4; n++) begin
      cmdq[0].push_back('{1'($urandom()), $urandom() & 32'hFFFF_FFFC, $urandom()});
      cmdq[2].push_back('{1'($urandom()), $urandom() & 32'hFFFF_FFFC, $urandom()});
    end
    model_build();
    wait_done(8, 80, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alt_count: got %0d rsp expected 8", rlog.size()); end
    for (int k = 0; k < 8 && k < rlog.size() && k < glog.size(); k++) begin
      int want;
      logic [DW-1:0] rd;
      want = (k % 2 == 0) ? 0 : 2;
      rd   = exp_q[k].c.write ? '0 : slave_data(exp_q[k].c.addr);
      checks++;
      if (glog[k].idx != want || rlog[k].idx != want)
        begin errors++; $display("FAIL alt_order[%0d]: got %0d expected %0d", k, glog[k].idx, want); end
      checks++;
      if (rlog[k].rdata !== rd)
        begin errors++; $display("FAIL alt_rdata[%0d]: got %h expected %h", k, rlog[k].rdata, rd); end
    end
  endtask

  task automatic test_single_write();
    start_batch();
    cmdq[0].push_back('{1'b1, 32'h0, 32'h0000_0309});
    model_build();
    tick(1);
    checks++;
    if ({PSEL, PENABLE, PWRITE, busy, req_ready} !== {4'b1011, 4'b0001})
      begin errors++; $display("FAIL wr_setup: got %b expected 10110001", {PSEL, PENABLE, PWRITE, busy, req_ready}); end
    checks++;
    if ({PRWADDR, PRWDATA} !== {32'h0, 32'h0000_0309})
      begin errors++; $display("FAIL wr_payload: got %h/%h expected 0/309", PRWADDR, PRWDATA); end
    tick(1);
    checks++;
    if ({PSEL, PENABLE, req_ready, rsp_valid} !== {2'b11, 8'b0})
      begin errors++; $display("FAIL wr_access: got %b expected 1100000000", {PSEL, PENABLE, req_ready, rsp_valid}); end
    tick(1);
    checks++;
    if ({rsp_valid, rsp_err, PSEL, PENABLE, busy} !== {4'b0001, 4'b0})
      begin errors++; $display("FAIL wr_rsp: got %b expected 00010000", {rsp_valid, rsp_err, PSEL, PENABLE, busy}); end
    checks++;
    if (rsp_rdata !== '0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rsp_rdata); end
    tick(1);
    checks++;
    if ({rsp_valid, PWRITE, PRWDATA} !== {4'b0, 1'b1, 32'h0000_0309})
      begin errors++; $display("FAIL wr_hold: got %b/%h expected 0000_1/309", {rsp_valid, PWRITE}, PRWDATA); end
    tick(1);
  endtask

  task automatic test_wait_states();
    start_batch();
    wait_plan.push_back(3);
    cmdq[1].push_back('{1'b0, 32'h8, 32'h0});
    model_build();
    tick(1);
    checks++;
    if ({PSEL, PENABLE, req_ready} !== 6'b10_0010)
      begin errors++; $display("FAIL ws_setup: got %b expected 100010", {PSEL, PENABLE, req_ready}); end
    for (int c = 0; c < 4; c++) begin
      tick(1);
      checks++;
      if ({PSEL, PENABLE, rsp_valid, PRWADDR} !== {2'b11, 4'b0, 32'h8})
        begin errors++; $display("FAIL ws_access[%0d]: got %b/%h expected 110000/8", c, {PSEL, PENABLE, rsp_valid}, PRWADDR); end
    end
    tick(1);
    checks++;
    if ({rsp_valid, rsp_err, PSEL} !== 6'b0010_00)
      begin errors++; $display("FAIL ws_rsp: got %b expected 001000", {rsp_valid, rsp_err, PSEL}); end
    checks++;
    if (rsp_rdata !== 32'h4d4f544f)
      begin errors++; $display("FAIL ws_rdata: got %h expected 4d4f544f", rsp_rdata); end
    tick(2);
  endtask

  task automatic test_timeout();
    bit ok;
    start_batch();
    cmdq[3].push_back('{1'b0, 32'h10, 32'h0});
    cmdq[3].push_back('{1'b0, 32'h14, 32'h0});
    cmdq[3].push_back('{1'b0, 32'h18, 32'h0});
    cmdq[1].push_back('{1'b0, 32'h40, 32'h0});
    wait_plan = '{100, 0, TO - 1, TO};
    model_build();
    wait_done(4, 150, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_count: got %0d rsp expected 4", rlog.size()); end
    for (int k = 0; k < 4 && k < rlog.size() && k < glog.size(); k++) begin
      logic          err_e;
      logic [DW-1:0] rd_e;
      int            dur_e;
      err_e = (exp_q[k].w >= TO);
      rd_e  = err_e ? '0 : slave_data(exp_q[k].c.addr);
      dur_e = err_e ? TO + 1 : exp_q[k].w + 2;
      checks++;
      if (rlog[k].idx != exp_q[k].idx)
        begin errors++; $display("FAIL to_idx[%0d]: got %0d expected %0d", k, rlog[k].idx, exp_q[k].idx); end
      checks++;
      if ({rlog[k].err, rlog[k].rdata} !== {err_e, rd_e})
        begin errors++; $display("FAIL to_rsp[%0d]: got err=%b rdata=%h expected err=%b rdata=%h", k, rlog[k].err, rlog[k].rdata, err_e, rd_e); end
      checks++;
      if (rlog[k].cyc - glog[k].cyc != dur_e)
        begin errors++; $display("FAIL to_dur[%0d]: got %0d expected %0d", k, rlog[k].cyc - glog[k].cyc, dur_e); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t = 0;
    start_batch();
    wait_plan.push_back(10);
    cmdq[2].push_back('{1'b0, 32'h20, 32'h0});
    while (!(PSEL && PENABLE) && t < 20) begin
      tick(1);
      t++;
    end
    checks++;
    if (!(PSEL && PENABLE)) begin errors++; $display("FAIL rstmid_reach: got %b expected 11", {PSEL, PENABLE}); end
    tick(2);
    #2 PRESET = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, busy} !== 3'b000)
      begin errors++; $display("FAIL rstmid_async: got %b expected 000", {PSEL, PENABLE, busy}); end
    cmdq[1].push_back('{1'b0, 32'h44, 32'h0});
    cmdq[0].push_back('{1'b0, 32'h48, 32'h0});
    wait_plan.delete();
    model_last = N - 1;
    tick(3);
    checks++;
    if (rlog.size() != 0) begin errors++; $display("FAIL rstmid_norsp: got %0d rsp expected 0", rlog.size()); end
    glog.delete();
    rlog.delete();
    PRESET = 1'b1;
    model_build();
    wait_done(2, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_count: got %0d rsp expected 2", rlog.size()); end
    checks++;
    if (glog.size() < 2 || glog[0].idx != 0 || glog[1].idx != 1)
      begin errors++; $display("FAIL rstmid_order: got %0d grants first %0d expected 0 then 1", glog.size(), (glog.size() > 0) ? glog[0].idx : -1); end
  endtask

  task automatic test_random();
    bit ok;
    for (int round = 0; round < 4; round++) begin
      int total = 0;
      start_batch();
      for (int i = 0; i < N; i++) begin
        int cnt_i = $urandom_range(0, 3);
        for (int n = 0; n < cnt_i; n++)
          cmdq[i].push_back('{1'($urandom()), $urandom() & 32'hFFFF_FFFC, $urandom()});
        total += cnt_i;
      end
      if (total == 0) begin
        cmdq[$urandom_range(0, N - 1)].push_back('{1'b0, 32'h100, 32'h0});
        total = 1;
      end
      for (int n = 0; n < total; n++) begin
        int r = $urandom_range(0, 9);
        wait_plan.push_back((r < 6) ? (r % 4) : (r == 6) ? TO - 1 : (r == 7) ? TO : TO + 4);
      end
      model_build();
      wait_done(total, total * 25 + 10, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd_count[%0d]: got %0d rsp expected %0d", round, rlog.size(), total); end
      for (int k = 0; k < total && k < rlog.size() && k < glog.size(); k++) begin
        logic          err_e;
        logic [DW-1:0] rd_e;
        int            dur_e;
        err_e = (exp_q[k].w >= TO);
        rd_e  = (exp_q[k].c.write || err_e) ? '0 : slave_data(exp_q[k].c.addr);
        dur_e = err_e ? TO + 1 : exp_q[k].w + 2;
        checks++;
        if (glog[k].idx != exp_q[k].idx || rlog[k].idx != exp_q[k].idx)
          begin errors++; $display("FAIL rnd_idx[%0d.%0d]: got %0d/%0d expected %0d", round, k, glog[k].idx, rlog[k].idx, exp_q[k].idx); end
        checks++;
        if ({glog[k].write, glog[k].addr, glog[k].wdata} !== {exp_q[k].c.write, exp_q[k].c.addr, exp_q[k].c.wdata})
          begin errors++; $display("FAIL rnd_payload[%0d.%0d]: got %b/%h/%h expected %b/%h/%h", round, k, glog[k].write, glog[k].addr, glog[k].wdata, exp_q[k].c.write, exp_q[k].c.addr, exp_q[k].c.wdata); end
        checks++;
        if ({rlog[k].err, rlog[k].rdata} !== {err_e, rd_e})
          begin errors++; $display("FAIL rnd_rsp[%0d.%0d]: got err=%b rdata=%h expected err=%b rdata=%h", round, k, rlog[k].err, rlog[k].rdata, err_e, rd_e); end
        checks++;
        if (rlog[k].cyc - glog[k].cyc != dur_e)
          begin errors++; $display("FAIL rnd_dur[%0d.%0d]: got %0d expected %0d", round, k, rlog[k].cyc - glog[k].cyc, dur_e); end
        if (k > 0) begin
          checks++;
          if (glog[k].cyc != rlog[k-1].cyc + 1)
            begin errors++; $display("FAIL rnd_b2b[%0d.%0d]: got gap %0d expected 1", round, k, glog[k].cyc - rlog[k-1].cyc); end
        end
      end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL rnd_stable[%0d]: got %0d changes expected 0", round, unstable); end
    end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_alternating();
    test_single_write();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
